// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, issues one 32-bit fetch at a time
// over a req/ack port, hands the instruction to decode with valid/ready, and
// follows jump/branch redirects from execute.
module inst_fetch #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_ack,
  input  logic [63:0] if_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        pc_jmp,
  input  logic [63:0] pc_jmpaddr,
  output logic        misalign,
  output logic [63:0] inst_cnt
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [ILEN-1:0]   r_inst;
  logic [XLEN-1:0]   r_inst_pc;
  logic              r_misalign;
  logic [XLEN-1:0]   r_inst_cnt;

  logic [ILEN-1:0]   w_word;
  logic              w_consume;
  logic              w_jmp_misaligned;

  // Select the 32-bit word of the fetched doubleword addressed by the PC.
  assign w_word           = r_pc[2] ? if_rdata[63:32] : if_rdata[31:0];
  assign w_consume        = (r_state == S_VALID) && inst_ready;
  assign w_jmp_misaligned = (pc_jmpaddr[1:0] != 2'b00);

  // Outputs: request and valid follow the state; data outputs are registers.
  assign if_req     = (r_state == S_REQ) && !rst;
  assign if_addr    = r_pc;
  assign inst_valid = (r_state == S_VALID);
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign misalign   = r_misalign;
  assign inst_cnt   = r_inst_cnt;

  // Fetch FSM with PC, captured instruction, fault flag and consume counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= PC_RESET;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_misalign <= 1'b0;
      r_inst_cnt <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (if_ack) begin
            r_inst    <= w_word;
            r_inst_pc <= r_pc;
            r_state   <= S_VALID;
          end
        end
        S_VALID: begin
          if (w_consume) begin
            r_inst_cnt <= r_inst_cnt + XLEN'(1);
            if (!pc_jmp) begin
              r_pc    <= r_pc + XLEN'(4);
              r_state <= S_REQ;
            end else if (!w_jmp_misaligned) begin
              r_pc    <= pc_jmpaddr;
              r_state <= S_REQ;
            end else begin
              // Keep the faulting target visible on if_addr for debug.
              r_pc       <= pc_jmpaddr;
              r_misalign <= 1'b1;
              r_state    <= S_HALT;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the fetch stage.
module tb_inst_fetch;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [63:0] if_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        pc_jmp;
  logic [63:0] pc_jmpaddr;
  logic        misalign;
  logic [63:0] inst_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch #(.PC_RESET(PC_RST)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .pc_jmp     (pc_jmp),
    .pc_jmpaddr (pc_jmpaddr),
    .misalign   (misalign),
    .inst_cnt   (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage should be doing, in transaction terms.
  // m_waiting: a fetch of m_pc is outstanding; m_holding: an instruction is
  // offered to decode; otherwise the stage is stopped on a bad jump target.
  bit          model_ok = 0;
  bit          m_waiting;
  bit          m_holding;
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [63:0] m_ipc;
  logic [63:0] m_cnt;
  bit          m_mis;

  always @(posedge clk) begin
    if (rst) begin
      model_ok  = 1;
      m_waiting = 1;
      m_holding = 0;
      m_pc      = PC_RST;
      m_inst    = 32'h0;
      m_ipc     = 64'h0;
      m_cnt     = 64'h0;
      m_mis     = 0;
    end else if (m_waiting && if_ack) begin
      m_inst    = 32'(if_rdata >> (m_pc[2] ? 32 : 0));
      m_ipc     = m_pc;
      m_waiting = 0;
      m_holding = 1;
    end else if (m_holding && inst_ready) begin
      m_cnt     = m_cnt + 64'd1;
      m_holding = 0;
      if (!pc_jmp) begin
        m_pc      = m_pc + 64'd4;
        m_waiting = 1;
      end else begin
        m_pc = pc_jmpaddr;
        if (pc_jmpaddr % 4 == 0) m_waiting = 1;
        else m_mis = 1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("if_req",     {63'h0, if_req},     {63'h0, (m_waiting && !rst)});
      chk("if_addr",    if_addr,             m_pc);
      chk("inst_valid", {63'h0, inst_valid}, {63'h0, m_holding});
      chk("inst",       {32'h0, inst},       {32'h0, m_inst});
      chk("inst_pc",    inst_pc,             m_ipc);
      chk("misalign",   {63'h0, misalign},   {63'h0, m_mis});
      chk("inst_cnt",   inst_cnt,            m_cnt);
    end
  end

  // Drive inputs shortly after the falling edge so they are stable at posedge.
  task automatic set_in(input logic r, input logic a, input logic [63:0] d,
                        input logic rd, input logic j, input logic [63:0] ja);
    #1;
    rst = r; if_ack = a; if_rdata = d; inst_ready = rd; pc_jmp = j; pc_jmpaddr = ja;
  endtask

  logic [63:0] rdata0;
  logic [63:0] ja;
  int          sel;

  initial begin
    rst = 1'b1; if_ack = 1'b0; if_rdata = '0; inst_ready = 1'b0; pc_jmp = 1'b0; pc_jmpaddr = '0;
    rdata0 = 64'h0000_0013_0010_0093;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_if_req", {63'h0, if_req}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_inst_cnt", inst_cnt, 64'h0);
    chk("rst_misalign", {63'h0, misalign}, 64'h0);
    set_in(0, 0, '0, 0, 0, '0);

    // First fetch at the reset PC, low word.
    @(negedge clk);
    chk("d_req0", {63'h0, if_req}, 64'h1);
    chk("d_addr0", if_addr, 64'h8000_0000);
    set_in(0, 1, rdata0, 0, 0, '0);
    @(negedge clk);
    chk("d_valid0", {63'h0, inst_valid}, 64'h1);
    chk("d_inst0", {32'h0, inst}, 64'h0010_0093);
    chk("d_ipc0", inst_pc, 64'h8000_0000);
    chk("d_req_off", {63'h0, if_req}, 64'h0);

    // Sequential consume, high-word select.
    set_in(0, 0, '0, 1, 0, '0);
    @(negedge clk);
    chk("d_addr1", if_addr, 64'h8000_0004);
    chk("d_cnt1", inst_cnt, 64'd1);
    set_in(0, 1, rdata0, 0, 0, '0);
    @(negedge clk);
    chk("d_inst1", {32'h0, inst}, 64'h0000_0013);
    chk("d_ipc1", inst_pc, 64'h8000_0004);

    // Aligned redirect.
    set_in(0, 0, '0, 1, 1, 64'h8000_0100);
    @(negedge clk);
    chk("d_cnt2", inst_cnt, 64'd2);
    chk("d_addr2", if_addr, 64'h8000_0100);
    set_in(0, 1, 64'hDEAD_BEEF_0000_0513, 0, 0, '0);
    @(negedge clk);
    chk("d_inst2", {32'h0, inst}, 64'h0000_0513);

    // Backpressure with spurious acks.
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, {$urandom, $urandom}, 0, 1, 64'h1);
      @(negedge clk);
      chk("d_bp_inst", {32'h0, inst}, 64'h0000_0513);
      chk("d_bp_ipc", inst_pc, 64'h8000_0100);
      chk("d_bp_req", {63'h0, if_req}, 64'h0);
    end
    set_in(0, 0, '0, 1, 0, '0);
    @(negedge clk);

    // Wait states: address stable until the ack.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, {$urandom, $urandom}, 1, 1, 64'h3);
      @(negedge clk);
      chk("d_ws_addr", if_addr, 64'h8000_0104);
      chk("d_ws_req", {63'h0, if_req}, 64'h1);
    end
    set_in(0, 1, 64'h1234_5678_9ABC_DEF0, 0, 0, '0);
    @(negedge clk);
    chk("d_ws_inst", {32'h0, inst}, 64'h1234_5678);

    // Misaligned target halts until reset.
    set_in(0, 0, '0, 1, 1, 64'h8000_0102);
    @(negedge clk);
    chk("d_mis", {63'h0, misalign}, 64'h1);
    chk("d_mis_addr", if_addr, 64'h8000_0102);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, {$urandom, $urandom}, 1, 0, '0);
      @(negedge clk);
      chk("d_halt_req", {63'h0, if_req}, 64'h0);
      chk("d_halt_valid", {63'h0, inst_valid}, 64'h0);
    end
    set_in(1, 0, '0, 0, 0, '0);
    @(negedge clk);
    chk("d_rst_mis", {63'h0, misalign}, 64'h0);
    set_in(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    chk("d_rst_addr", if_addr, 64'h8000_0000);

    // Reset while a request is outstanding.
    set_in(1, 0, '0, 0, 0, '0);
    @(negedge clk);
    chk("d_mid_req", {63'h0, if_req}, 64'h0);
    chk("d_mid_cnt", inst_cnt, 64'h0);
    set_in(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    chk("d_mid_req1", {63'h0, if_req}, 64'h1);
    chk("d_mid_addr", if_addr, 64'h8000_0000);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      ja = {$urandom, $urandom};
      else if (sel == 1) ja = 64'hFFFF_FFFF_FFFF_FFFC;
      else               ja = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4);
      set_in(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
             {$urandom, $urandom}, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, ja);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage for the single-issue RV64 core. It holds the PC and issues one 32-bit instruction fetch at a time over a req/ack memory port. It presents each fetched instruction to decode with a valid/ready handshake. It takes the jump/branch outcome back from the execute stage (pc_jmp, pc_jmpaddr) to choose the next PC.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
if_req  output  1  fetch request to instruction memory
if_addr  output  64  fetch address (= current PC), stable while if_req=1
if_ack  input  1  memory response; if_rdata valid in the same cycle
if_rdata  input  64  aligned 64-bit memory doubleword containing the PC
inst_valid  output  1  inst/inst_pc hold a fetched instruction
inst  output  32  fetched instruction
inst_pc  output  64  PC of inst
inst_ready  input  1  decode/execute consumes inst this cycle
pc_jmp  input  1  execute: redirect; meaningful only when inst_valid&inst_ready
pc_jmpaddr  input  64  execute: redirect target
misalign  output  1  sticky: redirect target not 4-byte aligned
inst_cnt  output  64  number of instructions consumed since reset

Behaviour:
- Reset (rst=1 at edge):
  - state<=S_REQ, pc<=PC_RESET.
  - Outputs after reset: if_req=0 during the rst cycles; inst_valid=0, inst=0, inst_pc=0, misalign=0, inst_cnt=0.
  - if_req is combinational from state (S_REQ & ~rst), so it is 1 in the first cycle after rst deasserts, with if_addr=PC_RESET.
  - Reset mid-operation aborts any outstanding request or held instruction with no side effects. The memory shares rst.
- States:
  - S_REQ: if_req=1, if_addr=pc, inst_valid=0. On if_ack: inst <= if_rdata[pc[2]*32 +: 32] (pc[2]=0 selects low word, 1 selects high word); inst_pc<=pc; go to S_VALID. An ack in the same cycle req first rises is legal.
  - S_VALID: if_req=0, inst_valid=1; inst and inst_pc are held stable. On inst_ready:
    - inst_cnt<=inst_cnt+1 (wraps modulo 2^64).
    - If pc_jmp=0: pc<=pc+4, go to S_REQ.
    - If pc_jmp=1 and pc_jmpaddr[1:0]==0: pc<=pc_jmpaddr, go to S_REQ.
    - If pc_jmp=1 and pc_jmpaddr[1:0]!=0: misalign<=1, pc<=pc_jmpaddr, go to S_HALT.
  - S_HALT: if_req=0, inst_valid=0. Only rst exits this state.
- Ignored inputs:
  - if_ack outside S_REQ is ignored; if_rdata is don't-care when if_ack=0.
  - pc_jmp and pc_jmpaddr are sampled only at the consume handshake; otherwise ignored.
  - inst_ready while inst_valid=0 has no effect.
- Latency: ack → inst_valid at the next edge. Consume → if_req at the next edge. Best-case throughput is one instruction per 2 cycles with zero-wait memory.
- One outstanding request at most; if_addr never changes while if_req=1 and no ack has been received.
- PC arithmetic is 64-bit and wraps modulo 2^64. pc+4 needs no alignment check: an aligned PC stays aligned.
- Only misaligned jump targets enter S_HALT; the target is still recorded in pc for debug visibility (if_addr reads the faulting target while if_req=0).

Test Plan:
- Reset then fetch: deassert rst; next cycle if_req=1, if_addr=0x80000000. Ack with if_rdata=0x00000013_00100093 → next cycle inst_valid=1, inst=0x00100093, inst_pc=0x80000000.
- Sequential/high-word select: consume with pc_jmp=0 → if_addr=0x80000004. Ack with the same rdata → inst=0x00000013; inst_cnt=1 after the first consume, 2 after the second.
- Redirect: consume with pc_jmp=1, pc_jmpaddr=0x80000100 → next if_addr=0x80000100. Ack with rdata high word 0xDEADBEEF, low word 0x00000513 → inst=0x00000513.
- Backpressure and wait states: ack delayed 3 cycles → if_addr stable throughout. Hold inst_ready=0 for 5 cycles → inst/inst_pc unchanged, if_req=0, and a spurious if_ack is ignored.
- Misaligned target: consume with pc_jmp=1, pc_jmpaddr=0x80000102 → misalign=1, inst_valid=0, if_req=0 indefinitely. Then rst pulse → misalign=0, if_addr=0x80000000.
- Reset mid-request: assert rst while in S_REQ before ack → if_req=0, inst_cnt=0. After release, fetch restarts at 0x80000000.
